apb_cfg_master: RTL and testbench

APB initiator that turns a simple valid/ready command stream into single APB transfers toward a register block, and returns read data and error status on a valid/ready response stream. Sits between firmware/test sequencers or an on-chip CPU bridge and the generated APB register blocks, one outstanding transfer at a time. A timeout watchdog converts a hung slave into an error response.

---
 rtl/apb_cfg_master_pkg.sv | 21 ++
 rtl/apb_cfg_master_if.sv | 42 ++++
 rtl/apb_cfg_master.sv | 118 +++++++++++
 tb/tb_apb_cfg_master.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cfg_master_pkg.sv
// Shared types and default sizing for the APB configuration master.
package apb_cfg_master_pkg;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

endpackage

// File: rtl/apb_cfg_master_if.sv
// Command/response streams plus the APB bus, bundled for the master and its environment.
interface apb_cfg_master_if #(
  parameter int unsigned ADDR_W = apb_cfg_master_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = apb_cfg_master_pkg::DATA_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwdata, psel, penable, pwrite
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwdata, psel, penable, pwrite
  );

endinterface

// File: rtl/apb_cfg_master.sv
// APB initiator: one valid/ready command in, one APB transfer out, one response back.
// A watchdog turns a slave that never raises pready into a timeout error response.
module apb_cfg_master
  import apb_cfg_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  apb_cfg_master_if.master bus
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_done;
  logic              w_limit;

  assign w_done  = bus.pready;
  // Counter is 0 in the first ACCESS cycle, so the abort lands on ACCESS cycle TIMEOUT+1.
  assign w_limit = (r_cnt == CNT_LIMIT);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_state     <= ST_SETUP;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_pwrite    <= bus.cmd_write;
            r_paddr     <= bus.cmd_addr;
            r_pwdata    <= bus.cmd_wdata;
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        ST_ACCESS: begin
          // pready on the limit cycle still completes normally.
          if (w_done) begin
            r_state       <= ST_RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
            r_rsp_err     <= bus.pslverr;
            r_rsp_timeout <= 1'b0;
          end else if (w_limit) begin
            r_state       <= ST_RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: behavioural APB register block plus a transaction-level response model.
module tb_apb_cfg_master;
  import apb_cfg_master_pkg::*;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int          TMO = 8;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  apb_cfg_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int slave_waits = 0;
  logic [31:0] exp_regs [512];

  function automatic logic [31:0] reset_val(int i);
    if (i == 1) return 32'h0001_0001;
    return 32'h9E37_79B9 * i ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] err_data(logic [11:0] a);
    return 32'hBADA_0000 | {20'h0, a};
  endfunction

  // Attached register block: mapped below 0x800, pslverr above; waits taken from slave_waits.
  initial begin : slave
    logic [31:0] regs [512];
    int acc_cnt;
    acc_cnt = 0;
    for (int i = 0; i < 512; i++) regs[i] = reset_val(i);
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    forever begin
      @(negedge clk);
      if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
        if (acc_cnt >= slave_waits) begin
          bus.pready  = 1'b1;
          bus.pslverr = bus.paddr[11];
          if (bus.paddr[11]) bus.prdata = err_data(bus.paddr);
          else if (bus.pwrite) begin
            regs[bus.paddr[10:2]] = bus.pwdata;
            bus.prdata = $urandom;
          end else bus.prdata = regs[bus.paddr[10:2]];
          acc_cnt = 0;
        end else begin
          bus.pready = 1'b0; bus.pslverr = 1'($urandom); bus.prdata = $urandom;
          acc_cnt++;
        end
      end else begin
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = $urandom;
        acc_cnt = 0;
      end
    end
  end

  function automatic rsp_t model_xfer(bit w, logic [11:0] a, logic [31:0] d, int waits);
    rsp_t r;
    if (waits > TMO) begin
      r.rdata = '0; r.err = 1'b1; r.timeout = 1'b1;
    end else if (a >= 12'h800) begin
      r.rdata = w ? 32'h0 : err_data(a); r.err = 1'b1; r.timeout = 1'b0;
    end else begin
      r.rdata = w ? 32'h0 : exp_regs[a[10:2]]; r.err = 1'b0; r.timeout = 1'b0;
      if (w) exp_regs[a[10:2]] = d;
    end
    return r;
  endfunction

  function automatic int model_lat(int waits);
    return 3 + ((waits > TMO) ? TMO : waits);
  endfunction

  // Drives one command from an idle DUT and reports what was observed; callers do the comparing.
  task automatic run_xfer(input bit w, input logic [11:0] a, input logic [31:0] d,
                          input int waits, input int hold,
                          output logic [31:0] rd, output logic e, output logic t, output int lat,
                          output bit apb_ok, output bit hold_ok, output bit idle_ok);
    slave_waits = waits;
    apb_ok = 1; hold_ok = 1; idle_ok = 1; lat = -1;
    rd = 'x; e = 1'bx; t = 1'bx;
    bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom);
    bus.cmd_addr = 12'($urandom); bus.cmd_wdata = $urandom;
    if (!(bus.psel === 1'b1 && bus.penable === 1'b0 && bus.paddr === a && bus.pwrite === w &&
          (!w || bus.pwdata === d))) apb_ok = 0;
    for (int c = 2; c < 64; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) begin lat = c; break; end
      if (!(bus.psel === 1'b1 && bus.penable === 1'b1 && bus.paddr === a && bus.pwrite === w &&
            (!w || bus.pwdata === d))) apb_ok = 0;
    end
    if (lat < 0) return;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0) apb_ok = 0;
    if (bus.cmd_ready !== 1'b0) hold_ok = 0;
    rd = bus.rsp_rdata; e = bus.rsp_err; t = bus.rsp_timeout;
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_rdata === rd && bus.rsp_err === e &&
            bus.rsp_timeout === t && bus.cmd_ready === 1'b0 && bus.psel === 1'b0)) hold_ok = 0;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    if (!(bus.cmd_ready === 1'b1 && bus.rsp_valid === 1'b0 && bus.psel === 1'b0)) idle_ok = 0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
         bus.cmd_ready} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000001", {bus.psel, bus.penable, bus.pwrite,
               bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.cmd_ready});
    end
    n_checks++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0", bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b psel=%b want 1/0", bus.cmd_ready, bus.psel);
    end
  endtask

  task automatic test_read_id();
    logic [31:0] rd; logic e, t; int lat; bit oa, oh, oi; rsp_t x;
    x = model_xfer(1'b0, 12'h004, 32'h0, 0);
    run_xfer(1'b0, 12'h004, 32'h0, 0, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t} !== {x.rdata, x.err, x.timeout} || rd !== 32'h0001_0001) begin
      n_fail++;
      $display("FAIL read_id_rsp: got %h/%b/%b want 00010001/0/0", rd, e, t);
    end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL read_id_latency: got %0d want 3", lat); end
    n_checks++;
    if ({oa, oh, oi} !== 3'b111) begin
      n_fail++; $display("FAIL read_id_protocol: got apb/hold/idle=%b want 111", {oa, oh, oi});
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e, t; int lat; bit oa, oh, oi; rsp_t x;
    x = model_xfer(1'b1, 12'h004, 32'hDEAD_BEEF, 0);
    run_xfer(1'b1, 12'h004, 32'hDEAD_BEEF, 0, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t, lat, oa, oi} !== {x.rdata, x.err, x.timeout, 32'd3, 2'b11}) begin
      n_fail++;
      $display("FAIL write_rsp: got %h/%b/%b lat=%0d apb=%b idle=%b want %h/%b/%b lat=3 apb=1 idle=1",
               rd, e, t, lat, oa, oi, x.rdata, x.err, x.timeout);
    end
    x = model_xfer(1'b0, 12'h004, 32'h0, 0);
    run_xfer(1'b0, 12'h004, 32'h0, 0, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t, lat, oa, oi} !== {x.rdata, x.err, x.timeout, 32'd3, 2'b11} ||
        rd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL readback_rsp: got %h/%b/%b lat=%0d apb=%b idle=%b want deadbeef/0/0 lat=3 apb=1 idle=1",
               rd, e, t, lat, oa, oi);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] rd; logic e, t; int lat; bit oa, oh, oi; rsp_t x;
    x = model_xfer(1'b0, 12'h800, 32'h0, 1);
    run_xfer(1'b0, 12'h800, 32'h0, 1, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t, lat} !== {x.rdata, x.err, x.timeout, 32'd4}) begin
      n_fail++;
      $display("FAIL slverr_read: got %h/%b/%b lat=%0d want %h/1/0 lat=4", rd, e, t, lat, x.rdata);
    end
    x = model_xfer(1'b1, 12'hFFC, 32'h1111_2222, 0);
    run_xfer(1'b1, 12'hFFC, 32'h1111_2222, 0, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t, oa, oi} !== {x.rdata, x.err, x.timeout, 2'b11}) begin
      n_fail++;
      $display("FAIL slverr_write: got %h/%b/%b apb=%b idle=%b want 0/1/0 apb=1 idle=1", rd, e, t, oa, oi);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic e, t; int lat; bit oa, oh, oi; rsp_t x;
    x = model_xfer(1'b0, 12'h010, 32'h0, 1000);
    run_xfer(1'b0, 12'h010, 32'h0, 1000, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t} !== {x.rdata, x.err, x.timeout}) begin
      n_fail++; $display("FAIL timeout_rsp: got %h/%b/%b want 0/1/1", rd, e, t);
    end
    n_checks++;
    if (lat !== model_lat(1000) || oa !== 1'b1) begin
      n_fail++; $display("FAIL timeout_latency: got %0d apb=%b want %0d apb=1", lat, oa, model_lat(1000));
    end
    x = model_xfer(1'b0, 12'h010, 32'h0, TMO);
    run_xfer(1'b0, 12'h010, 32'h0, TMO, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t, lat} !== {x.rdata, x.err, x.timeout, model_lat(TMO)}) begin
      n_fail++;
      $display("FAIL limit_ready: got %h/%b/%b lat=%0d want %h/0/0 lat=%0d", rd, e, t, lat, x.rdata, model_lat(TMO));
    end
    x = model_xfer(1'b1, 12'h014, 32'h1234_5678, 1000);
    run_xfer(1'b1, 12'h014, 32'h1234_5678, 1000, 0, rd, e, t, lat, oa, oh, oi);
    x = model_xfer(1'b0, 12'h014, 32'h0, 0);
    run_xfer(1'b0, 12'h014, 32'h0, 0, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t} !== {x.rdata, x.err, x.timeout}) begin
      n_fail++; $display("FAIL timeout_write_nochange: got %h/%b/%b want %h/0/0", rd, e, t, x.rdata);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic e, t; int lat; bit oa, oh, oi; rsp_t x;
    x = model_xfer(1'b0, 12'h004, 32'h0, 2);
    run_xfer(1'b0, 12'h004, 32'h0, 2, 10, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t, oh, oi} !== {x.rdata, x.err, x.timeout, 2'b11}) begin
      n_fail++;
      $display("FAIL backpressure: got %h/%b/%b hold=%b idle=%b want %h/0/0 hold=1 idle=1",
               rd, e, t, oh, oi, x.rdata);
    end
    x = model_xfer(1'b0, 12'h010, 32'h0, 0);
    run_xfer(1'b0, 12'h010, 32'h0, 0, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, lat} !== {x.rdata, 32'd3}) begin
      n_fail++; $display("FAIL resume_after_hold: got %h lat=%0d want %h lat=3", rd, lat, x.rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit w [6]; logic [11:0] a [6]; logic [31:0] d [6]; rsp_t x [6];
    int acc [$]; int got, issued, bad_gap; bit will_acc, data_ok;
    got = 0; issued = 0; bad_gap = 0; data_ok = 1;
    for (int i = 0; i < 6; i++) begin
      w[i] = (i % 2 == 0);
      a[i] = (i % 2 == 0) ? 12'(4 * $urandom_range(0, 15)) : a[i-1];
      d[i] = $urandom;
      x[i] = model_xfer(w[i], a[i], d[i], 0);
    end
    slave_waits = 0;
    bus.rsp_ready = 1'b1;
    bus.cmd_write = w[0]; bus.cmd_addr = a[0]; bus.cmd_wdata = d[0]; bus.cmd_valid = 1'b1;
    will_acc = (bus.cmd_ready === 1'b1);
    for (int c = 1; c < 80 && got < 6; c++) begin
      @(posedge clk); #1;
      if (will_acc) begin
        acc.push_back(c);
        issued++;
        if (issued < 6) begin
          bus.cmd_write = w[issued]; bus.cmd_addr = a[issued]; bus.cmd_wdata = d[issued];
        end else bus.cmd_valid = 1'b0;
      end
      if (bus.rsp_valid === 1'b1) begin
        if ({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== {x[got].rdata, x[got].err, x[got].timeout})
          data_ok = 0;
        got++;
      end
      will_acc = (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b0;
    for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 4) bad_gap = acc[i] - acc[i-1];
    n_checks++;
    if (got !== 6 || data_ok !== 1'b1) begin
      n_fail++; $display("FAIL b2b_data: got %0d responses ok=%b want 6 ok=1", got, data_ok);
    end
    n_checks++;
    if (acc.size() !== 6 || bad_gap !== 0) begin
      n_fail++; $display("FAIL b2b_throughput: got %0d accepts gap=%0d want 6 accepts gap=4", acc.size(), bad_gap);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d; logic e, t; int lat, waits, hold; bit oa, oh, oi, w; logic [11:0] a; rsp_t x;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 12'(12'h800 + 4 * $urandom_range(0, 511))
                                      : 12'(4 * $urandom_range(0, 15));
      d = $urandom;
      waits = ($urandom_range(0, 4) == 0) ? TMO + 1 + int'($urandom_range(0, 3))
                                          : int'($urandom_range(0, TMO));
      hold = int'($urandom_range(0, 3));
      x = model_xfer(w, a, d, waits);
      run_xfer(w, a, d, waits, hold, rd, e, t, lat, oa, oh, oi);
      n_checks++;
      if ({rd, e, t} !== {x.rdata, x.err, x.timeout}) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: w=%b a=%h waits=%0d got %h/%b/%b want %h/%b/%b",
                 i, w, a, waits, rd, e, t, x.rdata, x.err, x.timeout);
      end
      n_checks++;
      if ({lat, oa, oh, oi} !== {model_lat(waits), 3'b111}) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: got lat=%0d apb/hold/idle=%b want lat=%0d 111",
                 i, lat, {oa, oh, oi}, model_lat(waits));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e, t; int lat; bit oa, oh, oi, seen; rsp_t x;
    slave_waits = 1000;
    bus.cmd_write = 1'b0; bus.cmd_addr = 12'h008; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      n_fail++; $display("FAIL mid_pre_access: got psel/penable=%b want 11", {bus.psel, bus.penable});
    end
    rst_b = 1'b0;
    #1;
    n_checks++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_async_reset: got psel/penable/rsp_valid/cmd_ready=%b want 0001",
               {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_response: got activity=1 want 0"); end
    x = model_xfer(1'b0, 12'h004, 32'h0, 0);
    run_xfer(1'b0, 12'h004, 32'h0, 0, 0, rd, e, t, lat, oa, oh, oi);
    n_checks++;
    if ({rd, e, t, lat, oa, oi} !== {x.rdata, x.err, x.timeout, 32'd3, 2'b11}) begin
      n_fail++;
      $display("FAIL mid_recover: got %h/%b/%b lat=%0d want %h/0/0 lat=3", rd, e, t, lat, x.rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) exp_regs[i] = reset_val(i);
    test_reset();
    test_read_id();
    test_write_read();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
